// File: rtl/cell_core_moore.sv
// Per-cell execution core: runs the broadcast instruction stream against a local register file,
// with a Moore-neighbourhood source map, predicated execution and an iterative shift-add multiplier.
module cell_core_moore #(
  parameter int unsigned X               = 0,
  parameter int unsigned Y               = 0,
  parameter int unsigned REGISTER_LENGTH = 8,
  parameter int unsigned NUM_REGS        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [23:0]                instruction,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic                       execution_enable,
  input  logic                       frame_start,
  input  logic [REGISTER_LENGTH-1:0] i_my,
  input  logic [REGISTER_LENGTH-1:0] i_n,
  input  logic [REGISTER_LENGTH-1:0] i_s,
  input  logic [REGISTER_LENGTH-1:0] i_w,
  input  logic [REGISTER_LENGTH-1:0] i_e,
  input  logic [REGISTER_LENGTH-1:0] i_nw,
  input  logic [REGISTER_LENGTH-1:0] i_ne,
  input  logic [REGISTER_LENGTH-1:0] i_sw,
  input  logic [REGISTER_LENGTH-1:0] i_se,
  output logic [REGISTER_LENGTH-1:0] next_state,
  output logic [REGISTER_LENGTH-1:0] next_video,
  output logic                       flag,
  output logic                       busy
);

  localparam int unsigned W     = REGISTER_LENGTH;
  localparam int unsigned CNT_W = $clog2(W);

  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_LDI   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_CMPEQ = 4'd9;
  localparam logic [3:0] OP_CMPLT = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MIN   = 4'd12;
  localparam logic [3:0] OP_MAX   = 4'd13;
  localparam logic [3:0] OP_CNT   = 4'd14;

  localparam logic [4:0] SEL_VIDEO = 5'd27;
  localparam logic [4:0] SEL_STATE = 5'd28;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t            state;
  logic [W-1:0]      regs [NUM_REGS];
  logic [W-1:0]      src_tab [32];
  logic [W-1:0]      a, b;
  logic [3:0]        opcode;
  logic [1:0]        pred;
  logic [4:0]        target, src1, src2;
  logic              accept, pred_ok, exec;
  logic [3:0]        nbr_cnt;
  logic [W-1:0]      alu_res;
  logic              alu_wr, flag_wr, flag_val, mul_start;
  logic [W-1:0]      mul_mcand, mul_mplier, mul_acc, mul_acc_nxt;
  logic [CNT_W-1:0]  mul_cnt;
  logic [4:0]        mul_tgt;
  logic              mul_done;
  logic              wr_en;
  logic [4:0]        wr_tgt;
  logic [W-1:0]      wr_val;
  logic              unused_rsvd;

  assign opcode      = instruction[23:20];
  assign pred        = instruction[19:18];
  assign target      = instruction[14:10];
  assign src1        = instruction[9:5];
  assign src2        = instruction[4:0];
  assign unused_rsvd = ^instruction[17:15];

  // frame_start and reset both pre-empt instruction issue
  assign instr_ready = rst && !busy && !frame_start;
  assign accept      = instr_valid && instr_ready && execution_enable;

  always_comb begin : pred_eval
    pred_ok = 1'b0;
    case (pred)
      2'b00:   pred_ok = 1'b1;
      2'b01:   pred_ok = flag;
      2'b10:   pred_ok = !flag;
      default: pred_ok = 1'b0;
    endcase
  end

  assign exec = accept && pred_ok;

  // Operand source map; unpopulated codes read as zero
  always_comb begin : src_mux
    for (int unsigned i = 0; i < 32; i++) src_tab[i] = '0;
    src_tab[0] = i_my;
    for (int unsigned k = 0; k < NUM_REGS; k++) src_tab[k+1] = regs[k];
    src_tab[17] = W'(X);
    src_tab[18] = W'(Y);
    src_tab[19] = i_n;
    src_tab[20] = i_s;
    src_tab[21] = i_w;
    src_tab[22] = i_e;
    src_tab[23] = i_nw;
    src_tab[24] = i_ne;
    src_tab[25] = i_sw;
    src_tab[26] = i_se;
    src_tab[28] = next_state;
  end

  assign a = src_tab[src1];
  assign b = src_tab[src2];

  // At most 8 live neighbours, which always fits in W >= 4 bits
  assign nbr_cnt = 4'(i_n  != '0) + 4'(i_s  != '0) + 4'(i_w  != '0) + 4'(i_e  != '0)
                 + 4'(i_nw != '0) + 4'(i_ne != '0) + 4'(i_sw != '0) + 4'(i_se != '0);

  always_comb begin : alu
    alu_res   = '0;
    alu_wr    = 1'b0;
    flag_wr   = 1'b0;
    flag_val  = 1'b0;
    mul_start = 1'b0;
    if (exec) begin
      case (opcode)
        OP_ADD:   begin alu_res = a + b;  alu_wr = 1'b1; end
        OP_SUB:   begin alu_res = a - b;  alu_wr = 1'b1; end
        OP_AND:   begin alu_res = a & b;  alu_wr = 1'b1; end
        OP_OR:    begin alu_res = a | b;  alu_wr = 1'b1; end
        OP_XOR:   begin alu_res = a ^ b;  alu_wr = 1'b1; end
        OP_LDI:   begin alu_res = W'(instruction[9:0]); alu_wr = 1'b1; end
        OP_SHL:   begin alu_res = (32'(src2) >= W) ? '0 : (a << src2); alu_wr = 1'b1; end
        OP_SHR:   begin alu_res = (32'(src2) >= W) ? '0 : (a >> src2); alu_wr = 1'b1; end
        OP_CMPEQ: begin flag_wr = 1'b1; flag_val = (a == b); end
        OP_CMPLT: begin flag_wr = 1'b1; flag_val = (a < b); end
        OP_MUL:   mul_start = 1'b1;
        OP_MIN:   begin alu_res = (a < b) ? a : b; alu_wr = 1'b1; end
        OP_MAX:   begin alu_res = (a < b) ? b : a; alu_wr = 1'b1; end
        OP_CNT:   begin alu_res = W'(nbr_cnt); alu_wr = 1'b1; end
        default:  ;
      endcase
    end
  end

  // Shift-add multiplier: one multiplier bit per cycle, done on the W-th step
  assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_done    = (state == ST_MUL) && (mul_cnt == CNT_W'(W - 1));

  // Single write port shared by ALU results and multiplier completion (never concurrent)
  assign wr_en  = alu_wr || mul_done;
  assign wr_tgt = mul_done ? mul_tgt : target;
  assign wr_val = mul_done ? mul_acc_nxt : alu_res;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      state      <= ST_IDLE;
      busy       <= 1'b0;
      flag       <= 1'b0;
      next_state <= '0;
      next_video <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_cnt    <= '0;
      mul_tgt    <= '0;
    end else if (frame_start) begin
      next_state <= i_my;
      flag       <= 1'b0;
      busy       <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      if (wr_en) begin
        for (int unsigned k = 0; k < NUM_REGS; k++)
          if (wr_tgt == 5'(k + 1)) regs[k] <= wr_val;
        if (wr_tgt == SEL_VIDEO) next_video <= wr_val;
        if (wr_tgt == SEL_STATE) next_state <= wr_val;
      end
      if (flag_wr) flag <= flag_val;
      if (state == ST_IDLE) begin
        if (mul_start) begin
          mul_mcand  <= a;
          mul_mplier <= b;
          mul_acc    <= '0;
          mul_cnt    <= '0;
          mul_tgt    <= target;
          busy       <= 1'b1;
          state      <= ST_MUL;
        end
      end else begin
        mul_acc    <= mul_acc_nxt;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + CNT_W'(1);
        if (mul_done) begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule
